// File: rtl/period_classifier.sv
// Period meter and band classifier: measures rising-to-rising periods of an async
// input over a fixed window, then maps the longest period onto a threshold table.
module period_classifier #(
  parameter int CNT_W       = 16,
  parameter int WIN_LEN     = 1048576,
  parameter int NBANDS      = 10,
  parameter int BAND_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NBANDS*CNT_W-1:0] THR_INIT = {16'd1500, 16'd700, 16'd580, 16'd430, 16'd360,
                                                 16'd300,  16'd265, 16'd235, 16'd210, 16'd190}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sigin,
  input  logic                       thr_we,
  input  logic [$clog2(NBANDS)-1:0]  thr_addr,
  input  logic [CNT_W-1:0]           thr_data,
  output logic                       thr_busy,
  output logic [BAND_W-1:0]          band,
  output logic [CNT_W-1:0]           period_max,
  output logic [CNT_W-1:0]           period_min,
  output logic [CNT_W-1:0]           edge_cnt,
  output logic                       no_signal,
  output logic                       overflow,
  output logic                       meas_valid
);

  localparam int AW    = $clog2(NBANDS);
  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {MEASURE, CLASSIFY, REPORT} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  logic [WIN_W-1:0] win_cnt_q;
  logic             win_close;

  logic             armed_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] sample_d;
  logic [CNT_W-1:0] max_acc_q;
  logic [CNT_W-1:0] min_acc_q;
  logic [CNT_W-1:0] edge_acc_q;
  logic             ovf_acc_q;

  logic [CNT_W-1:0] snap_max_q;
  logic [CNT_W-1:0] snap_min_q;
  logic [CNT_W-1:0] snap_edges_q;
  logic             snap_ovf_q;

  logic [CNT_W-1:0] thr_q [NBANDS];
  logic             thr_addr_ok;

  state_e           state_q;
  logic [AW-1:0]    idx_q;
  logic [BAND_W-1:0] best_q;
  logic [BAND_W-1:0] best_d;

  logic [BAND_W-1:0] band_q;
  logic [CNT_W-1:0]  period_max_q;
  logic [CNT_W-1:0]  period_min_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic              no_signal_q;
  logic              overflow_q;
  logic              meas_valid_q;

  // Synchroniser resets to ones so a high input at reset release is not a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sigin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign win_close = (win_cnt_q == WIN_W'(WIN_LEN - 1));

  always_comb begin
    sample_d = per_cnt_q + CNT_W'(1);
    if (per_cnt_q == CNT_MAX) sample_d = CNT_MAX;
  end

  // Window accumulators; an edge landing on the close cycle is deliberately dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q    <= '0;
      armed_q      <= 1'b0;
      per_cnt_q    <= '0;
      max_acc_q    <= '0;
      min_acc_q    <= CNT_MAX;
      edge_acc_q   <= '0;
      ovf_acc_q    <= 1'b0;
      snap_max_q   <= '0;
      snap_min_q   <= '0;
      snap_edges_q <= '0;
      snap_ovf_q   <= 1'b0;
    end else begin
      win_cnt_q <= win_close ? '0 : win_cnt_q + WIN_W'(1);
      if (win_close) begin
        snap_max_q   <= max_acc_q;
        snap_min_q   <= min_acc_q;
        snap_edges_q <= edge_acc_q;
        snap_ovf_q   <= ovf_acc_q;
        armed_q      <= 1'b0;
        per_cnt_q    <= '0;
        max_acc_q    <= '0;
        min_acc_q    <= CNT_MAX;
        edge_acc_q   <= '0;
        ovf_acc_q    <= 1'b0;
      end else if (rise) begin
        if (edge_acc_q != CNT_MAX) edge_acc_q <= edge_acc_q + CNT_W'(1);
        if (armed_q) begin
          if (sample_d > max_acc_q) max_acc_q <= sample_d;
          if (sample_d < min_acc_q) min_acc_q <= sample_d;
        end
        armed_q   <= 1'b1;
        per_cnt_q <= '0;
      end else if (armed_q && per_cnt_q != CNT_MAX) begin
        per_cnt_q <= per_cnt_q + CNT_W'(1);
        if (per_cnt_q == CNT_MAX - CNT_W'(1)) ovf_acc_q <= 1'b1;
      end
    end
  end

  assign thr_addr_ok = (32'(thr_addr) < 32'(NBANDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBANDS; i++) thr_q[i] <= THR_INIT[(NBANDS-1-i)*CNT_W +: CNT_W];
    end else if (thr_we && state_q != CLASSIFY && thr_addr_ok) begin
      thr_q[thr_addr] <= thr_data;
    end
  end

  // First matching threshold wins; later matches never overwrite it.
  always_comb begin
    best_d = best_q;
    if (best_q == '0 && snap_max_q > thr_q[idx_q]) best_d = BAND_W'(idx_q) + BAND_W'(1);
  end

  // Results are loaded on the last compare so meas_valid lands NBANDS+1 cycles after close.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MEASURE;
      idx_q        <= '0;
      best_q       <= '0;
      band_q       <= '0;
      period_max_q <= '0;
      period_min_q <= '0;
      edge_cnt_q   <= '0;
      no_signal_q  <= 1'b0;
      overflow_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      case (state_q)
        MEASURE: begin
          meas_valid_q <= 1'b0;
          if (win_close) begin
            state_q <= CLASSIFY;
            idx_q   <= '0;
            best_q  <= '0;
          end
        end
        CLASSIFY: begin
          best_q <= best_d;
          if (idx_q == AW'(NBANDS - 1)) begin
            state_q      <= REPORT;
            meas_valid_q <= 1'b1;
            edge_cnt_q   <= snap_edges_q;
            overflow_q   <= snap_ovf_q;
            if (snap_edges_q < CNT_W'(2)) begin
              band_q       <= '0;
              period_max_q <= '0;
              period_min_q <= '0;
              no_signal_q  <= 1'b1;
            end else begin
              band_q       <= best_d;
              period_max_q <= snap_max_q;
              period_min_q <= snap_min_q;
              no_signal_q  <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        REPORT: begin
          meas_valid_q <= 1'b0;
          state_q      <= MEASURE;
        end
        default: begin
          meas_valid_q <= 1'b0;
          state_q      <= MEASURE;
        end
      endcase
    end
  end

  assign thr_busy   = (state_q == CLASSIFY);
  assign band       = band_q;
  assign period_max = period_max_q;
  assign period_min = period_min_q;
  assign edge_cnt   = edge_cnt_q;
  assign no_signal  = no_signal_q;
  assign overflow   = overflow_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_period_classifier.sv
// Directed bench for period_classifier: a 16-bit instance checks banding and window
// behaviour, a 5-bit instance on the same stimulus checks period-counter saturation.
module tb_period_classifier;

  localparam int CNT_W   = 16;
  localparam int SCNT_W  = 5;
  localparam int WIN_LEN = 256;
  localparam int NBANDS  = 10;
  localparam int BAND_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sigin;
  logic thr_we = 1'b0;
  logic [$clog2(NBANDS)-1:0] thr_addr = '0;
  logic [CNT_W-1:0]  thr_data  = '0;
  logic [SCNT_W-1:0] sThrData;

  logic              thr_busy, no_signal, overflow, meas_valid;
  logic [BAND_W-1:0] band;
  logic [CNT_W-1:0]  period_max, period_min, edge_cnt;

  logic               sThrBusy, sNoSignal, sOverflow, sMeasValid;
  logic [BAND_W-1:0]  sBand;
  logic [SCNT_W-1:0]  sPeriodMax, sPeriodMin, sEdgeCnt;

  logic genEn     = 1'b0;
  logic genSig    = 1'b0;
  logic manualSig = 1'b0;
  int   genPerA   = 40;
  int   genPerB   = 40;

  int vectors     = 0;
  int miscompares = 0;

  assign sigin    = genEn ? genSig : manualSig;
  assign sThrData = thr_data[SCNT_W-1:0];

  always #5 clk = ~clk;

  period_classifier #(
    .CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .NBANDS(NBANDS), .BAND_W(BAND_W), .SYNC_STAGES(2),
    .THR_INIT({16'd150, 16'd70, 16'd58, 16'd43, 16'd36, 16'd30, 16'd26, 16'd23, 16'd21, 16'd19})
  ) dut (
    .clk(clk), .rst(rst), .sigin(sigin),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data), .thr_busy(thr_busy),
    .band(band), .period_max(period_max), .period_min(period_min), .edge_cnt(edge_cnt),
    .no_signal(no_signal), .overflow(overflow), .meas_valid(meas_valid)
  );

  period_classifier #(
    .CNT_W(SCNT_W), .WIN_LEN(WIN_LEN), .NBANDS(NBANDS), .BAND_W(BAND_W), .SYNC_STAGES(2),
    .THR_INIT({5'd30, 5'd28, 5'd26, 5'd24, 5'd22, 5'd20, 5'd18, 5'd16, 5'd14, 5'd12})
  ) dutSmall (
    .clk(clk), .rst(rst), .sigin(sigin),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(sThrData), .thr_busy(sThrBusy),
    .band(sBand), .period_max(sPeriodMax), .period_min(sPeriodMin), .edge_cnt(sEdgeCnt),
    .no_signal(sNoSignal), .overflow(sOverflow), .meas_valid(sMeasValid)
  );

  // Square-wave source alternating between two periods; high for half of each period.
  initial begin : generator
    bit useB;
    int p;
    useB = 1'b0;
    forever begin
      if (!genEn) begin
        genSig = 1'b0;
        @(negedge clk);
      end else begin
        p    = useB ? genPerB : genPerA;
        useB = !useB;
        genSig = 1'b1;
        repeat (p / 2) @(negedge clk);
        genSig = 1'b0;
        repeat (p - p / 2) @(negedge clk);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int perA, input int perB);
    genPerA = perA;
    genPerB = perB;
    genEn   = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitReport(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_seen"}, 32'(got), 1);
  endtask

  task automatic waitBusy(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (thr_busy === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_busy"}, 32'(got), 1);
  endtask

  task automatic writeThr(input int addr, input int data);
    thr_addr = ($clog2(NBANDS))'(addr);
    thr_data = CNT_W'(data);
    thr_we   = 1'b1;
    @(negedge clk);
    thr_we   = 1'b0;
  endtask

  initial begin
    logic sawValid;
    int   rep;

    doReset();
    checkOutput("rstBand", 32'(band), 0);
    checkOutput("rstMax", 32'(period_max), 0);
    checkOutput("rstValid", 32'(meas_valid), 0);
    checkOutput("rstNoSig", 32'(no_signal), 0);
    checkOutput("rstBusy", 32'(thr_busy), 0);

    // Input held low: no edges at all
    waitReport("low");
    checkOutput("lowEdges", 32'(edge_cnt), 0);
    checkOutput("lowNoSig", 32'(no_signal), 1);
    checkOutput("lowBand", 32'(band), 0);
    checkOutput("lowMax", 32'(period_max), 0);

    // Input high through reset release must not register an edge
    manualSig = 1'b1;
    doReset();
    waitReport("high");
    checkOutput("highEdges", 32'(edge_cnt), 0);
    checkOutput("highNoSig", 32'(no_signal), 1);
    checkOutput("highBand", 32'(band), 0);
    checkOutput("highMax", 32'(period_max), 0);

    // Period 40: band 5 on the wide instance, saturation on the narrow one
    applyStimulus(40, 40);
    waitReport("p40a");
    waitReport("p40b");
    checkOutput("p40Max", 32'(period_max), 40);
    checkOutput("p40Min", 32'(period_min), 40);
    checkOutput("p40Edges", 32'(edge_cnt >= 6 && edge_cnt <= 7), 1);
    checkOutput("p40Band", 32'(band), 5);
    checkOutput("p40NoSig", 32'(no_signal), 0);
    checkOutput("p40Ovf", 32'(overflow), 0);
    checkOutput("p40SmallValid", 32'(sMeasValid), 1);
    checkOutput("p40SmallOvf", 32'(sOverflow), 1);
    checkOutput("p40SmallMax", 32'(sPeriodMax), 31);
    @(negedge clk);
    checkOutput("mvPulse", 32'(meas_valid), 0);
    checkOutput("holdBand", 32'(band), 5);

    // Period 20: matches only the last threshold
    applyStimulus(20, 20);
    waitReport("p20a");
    waitReport("p20b");
    checkOutput("p20Max", 32'(period_max), 20);
    checkOutput("p20Min", 32'(period_min), 20);
    checkOutput("p20Band", 32'(band), 10);
    checkOutput("p20SmallOvf", 32'(sOverflow), 0);
    checkOutput("p20SmallMax", 32'(sPeriodMax), 20);

    // Alternating 20/30: 30 is not strictly above 30, first match is 26 at index 6
    applyStimulus(20, 30);
    waitReport("altA");
    waitReport("altB");
    checkOutput("altMax", 32'(period_max), 30);
    checkOutput("altMin", 32'(period_min), 20);
    checkOutput("altBand", 32'(band), 7);

    // Period 15: below every threshold
    applyStimulus(15, 15);
    waitReport("p15a");
    waitReport("p15b");
    checkOutput("p15Band", 32'(band), 0);
    checkOutput("p15NoSig", 32'(no_signal), 0);
    checkOutput("p15Max", 32'(period_max), 15);

    // Idle-time threshold write takes effect
    applyStimulus(40, 40);
    waitReport("wrIdleA");
    repeat (3) @(negedge clk);
    checkOutput("idleBusy", 32'(thr_busy), 0);
    writeThr(0, 10);
    waitReport("wrIdleB");
    waitReport("wrIdleC");
    checkOutput("wrIdleBand", 32'(band), 1);

    // Reset a few cycles into classification abandons that window and restores thresholds
    waitBusy("rstCls");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstClsBand", 32'(band), 0);
    checkOutput("rstClsMax", 32'(period_max), 0);
    checkOutput("rstClsEdges", 32'(edge_cnt), 0);
    checkOutput("rstClsValid", 32'(meas_valid), 0);
    sawValid = 1'b0;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("rstClsNoStale", 32'(sawValid), 0);
    waitReport("rstClsNext");
    checkOutput("rstClsThrBand", 32'(band), 5);
    checkOutput("rstClsThrMax", 32'(period_max), 40);

    // Write attempted while busy is dropped
    waitBusy("wrBusy");
    thr_addr = '0;
    thr_data = CNT_W'(10);
    thr_we   = 1'b1;
    @(negedge clk);
    thr_we   = 1'b0;
    waitReport("wrBusyA");
    checkOutput("wrBusyBandA", 32'(band), 5);
    waitReport("wrBusyB");
    checkOutput("wrBusyBandB", 32'(band), 5);

    // Edge on the close cycle belongs to neither window
    genEn     = 1'b0;
    manualSig = 1'b0;
    doReset();
    rep = 0;
    for (int n = 0; n < 540; n++) begin
      manualSig = ((n >= 20 && n < 25) || (n >= 50 && n < 55) || (n >= 253 && n < 258) ||
                   (n >= 356 && n < 361) || (n >= 386 && n < 391));
      if (meas_valid === 1'b1) begin
        if (rep == 0) begin
          checkOutput("closeW1At", 32'(n), 266);
          checkOutput("closeW1Edges", 32'(edge_cnt), 2);
          checkOutput("closeW1Max", 32'(period_max), 30);
          checkOutput("closeW1Min", 32'(period_min), 30);
        end else begin
          checkOutput("closeW2At", 32'(n), 522);
          checkOutput("closeW2Edges", 32'(edge_cnt), 2);
          checkOutput("closeW2Max", 32'(period_max), 30);
          checkOutput("closeW2Min", 32'(period_min), 30);
        end
        rep++;
      end
      @(negedge clk);
    end
    checkOutput("closeReports", 32'(rep), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
